// File: rtl/alarm_timer.sv
// alarm_timer: countdown timer and four-slot delay store for the anti-theft FSM.
// Generates its own 1 Hz time base from clk, counts down the selected slot in
// whole seconds and returns a single-cycle expired pulse when it reaches zero.
module alarm_timer #(
    parameter int CLK_HZ        = 27000000,
    parameter int DEF_ARM       = 6,
    parameter int DEF_DRIVER    = 8,
    parameter int DEF_PASSENGER = 15,
    parameter int DEF_ALARM_ON  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] param_sel,
    input  logic [3:0] param_value,
    output logic       expired,
    output logic       busy,
    output logic [3:0] remaining,
    output logic       one_hz
);

    // A divider of one cycle per second still needs a one-bit counter.
    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_COUNT = 1'b1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             one_hz_q, one_hz_d;
    logic [3:0]       slot_q [4];
    logic [3:0]       slot_d [4];
    logic [0:0]       state_q, state_d;
    logic [3:0]       remaining_q, remaining_d;
    logic             expired_q, expired_d;
    logic             wrap;
    logic [3:0]       sel_value;
    logic             fire;

    assign wrap      = (div_q == DIV_LAST);
    assign sel_value = slot_q[interval];

    // Free-running second divider; a start realigns it so the first second is whole.
    always_comb begin
        div_d    = div_q + 1'b1;
        one_hz_d = wrap;
        if (wrap || start_timer) begin
            div_d = '0;
        end
    end

    // Slot writes land at the edge; a load in the same cycle still sees the old value.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (reprogram) begin
            slot_d[param_sel] = param_value;
        end
    end

    // Countdown FSM: a start always wins over a coinciding final wrap.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        fire        = 1'b0;
        if (start_timer) begin
            if (sel_value != 4'd0) begin
                remaining_d = sel_value;
                state_d     = ST_COUNT;
            end else begin
                remaining_d = 4'd0;
                state_d     = ST_IDLE;
                fire        = 1'b1;
            end
        end else if (state_q == ST_COUNT && wrap) begin
            if (remaining_q == 4'd1) begin
                remaining_d = 4'd0;
                state_d     = ST_IDLE;
                fire        = 1'b1;
            end else begin
                remaining_d = remaining_q - 4'd1;
            end
        end
        // A held start on an empty slot must not stretch the pulse past one cycle.
        expired_d = fire && !expired_q;
    end

    // State registers with synchronous reset back to the default delays.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            one_hz_q    <= 1'b0;
            slot_q[0]   <= 4'(DEF_ARM);
            slot_q[1]   <= 4'(DEF_DRIVER);
            slot_q[2]   <= 4'(DEF_PASSENGER);
            slot_q[3]   <= 4'(DEF_ALARM_ON);
            state_q     <= ST_IDLE;
            remaining_q <= 4'd0;
            expired_q   <= 1'b0;
        end else begin
            div_q       <= div_d;
            one_hz_q    <= one_hz_d;
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= slot_d[i];
            end
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
        end
    end

    assign expired   = expired_q;
    assign busy      = (state_q == ST_COUNT);
    assign remaining = remaining_q;
    assign one_hz    = one_hz_q;

endmodule
